fft_blk_sched: RTL and testbench

Block scheduler for the 16-lane radix butterfly pipeline. Issues one frame of `cfg_nblk` parallel 16-sample blocks into the first butterfly stage through an upstream valid/ready handshake. Tags each issued block with its index and start/end-of-frame markers, and throttles issue against credits from the downstream output FIFO, because the butterfly stages have no stall input. It tracks blocks in flight until the last stage's `valid_out` has returned every one, then signals frame completion.

---
 rtl/fft_blk_sched_if.sv | 11 +
 rtl/fft_blk_sched.sv | 76 +++++++
 tb/tb_fft_blk_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fft_blk_sched_if.sv
// fft_blk_sched_if: block issue handshake between upstream source, scheduler and butterfly stage 1
interface fft_blk_sched_if #(parameter int BLK_W = 6);
  logic in_valid;
  logic in_ready;
  logic bf_valid;
  logic sof;
  logic eof;
  logic [BLK_W-1:0] blk_idx;
  modport master(output in_valid, input in_ready, bf_valid, blk_idx, sof, eof);
  modport slave(input in_valid, output in_ready, bf_valid, blk_idx, sof, eof);
endinterface

// File: rtl/fft_blk_sched.sv
// fft_blk_sched: issues a frame of blocks into the butterfly pipeline under downstream credit control
module fft_blk_sched #(
  parameter int MAX_BLK = 32,
  parameter int BLK_W   = $clog2(MAX_BLK) + 1,
  parameter int CREDITS = 8,
  parameter int CNT_W   = $clog2(CREDITS) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [BLK_W-1:0] cfg_nblk,
  fft_blk_sched_if.slave   bus,
  input  logic             pipe_vout,
  input  logic             sink_pop,
  output logic             busy,
  output logic             done,
  output logic [2:0]       err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [BLK_W-1:0] MAX_V  = BLK_W'(MAX_BLK);
  localparam logic [CNT_W-1:0] CRED_V = CNT_W'(CREDITS);
  state_t           state_q, state_d;
  logic [BLK_W-1:0] nblk_q, nblk_d, blk_idx_q, blk_idx_d;
  logic [CNT_W-1:0] credit_q, credit_d, inflight_q, inflight_d;
  logic [2:0]       err_q, err_d;
  logic             issue, cfg_ok, vout_unf, pop_ovf;
  assign bus.in_ready = (state_q == RUN) && (credit_q != '0) && (blk_idx_q < nblk_q);
  assign issue        = bus.in_valid && bus.in_ready;
  assign bus.bf_valid = issue;
  assign bus.blk_idx  = blk_idx_q;
  assign bus.sof      = issue && (blk_idx_q == '0);
  assign bus.eof      = issue && (blk_idx_q == nblk_q - BLK_W'(1));
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign err          = err_q;
  assign cfg_ok       = (cfg_nblk != '0) && (cfg_nblk <= MAX_V);
  assign vout_unf     = pipe_vout && !issue && (inflight_q == '0);
  assign pop_ovf      = sink_pop && !issue && (credit_q == CRED_V);
  always_comb begin
    state_d    = state_q;
    nblk_d     = nblk_q;
    blk_idx_d  = issue ? blk_idx_q + BLK_W'(1) : blk_idx_q;
    inflight_d = (issue && !pipe_vout) ? inflight_q + CNT_W'(1) :
                 (!issue && pipe_vout && !vout_unf) ? inflight_q - CNT_W'(1) : inflight_q;
    credit_d   = (issue && !sink_pop) ? credit_q - CNT_W'(1) :
                 (!issue && sink_pop && !pop_ovf) ? credit_q + CNT_W'(1) : credit_q;
    err_d      = err_q | {pop_ovf, start && (state_q == IDLE) && !cfg_ok, vout_unf};
    case (state_q)
      IDLE: if (start && cfg_ok) begin
        nblk_d    = cfg_nblk;
        blk_idx_d = '0;
        state_d   = RUN;
      end
      RUN:   state_d = (issue && bus.eof) ? DRAIN : RUN;
      DRAIN: state_d = (inflight_d == '0) ? DONE : DRAIN;
      DONE:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      nblk_q     <= '0;
      blk_idx_q  <= '0;
      credit_q   <= CRED_V;
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      nblk_q     <= nblk_d;
      blk_idx_q  <= blk_idx_d;
      credit_q   <= credit_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_fft_blk_sched.sv
// tb_fft_blk_sched: directed checks of frame issue, credit stall, drain, errors and reset
module tb_fft_blk_sched;
  logic       clk = 0;
  logic       rstn = 0;
  logic       start = 0;
  logic [5:0] cfg_nblk = '0;
  logic       pipe_vout, sink_pop, busy, done;
  logic [2:0] err;
  logic       auto_md = 0, vout_man = 0, pop_man = 0;
  logic [1:0] pipe_q;
  int         n_tests = 0, n_fail = 0;
  fft_blk_sched_if #(.BLK_W(6)) bus();
  fft_blk_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_nblk(cfg_nblk), .bus(bus),
    .pipe_vout(pipe_vout), .sink_pop(sink_pop), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  // two-stage butterfly latency model; credits return in the issue cycle
  always @(posedge clk) pipe_q <= !rstn ? 2'b00 : {pipe_q[0], bus.bf_valid};
  assign pipe_vout = auto_md ? pipe_q[1] : vout_man;
  assign sink_pop  = auto_md ? bus.bf_valid : pop_man;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic kick(input logic [5:0] n);
    start = 1;
    cfg_nblk = n;
    step();
    start = 0;
  endtask
  initial begin
    int n;
    bus.in_valid = 1;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_bf_valid", bus.bf_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_idx", bus.blk_idx, 0);
    chk("rst_sof_eof", {bus.sof, bus.eof}, 0);
    rstn = 1;
    auto_md = 1;
    kick(4);
    chk("nom_ready", bus.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("nom_valid", bus.bf_valid, 1);
      chk("nom_idx", bus.blk_idx, i);
      chk("nom_sof", bus.sof, i == 0);
      chk("nom_eof", bus.eof, i == 3);
      step();
    end
    for (int k = 1; k <= 4; k++) begin
      chk("nom_done", done, k == 3);
      chk("nom_idle_valid", bus.bf_valid, 0);
      step();
    end
    chk("nom_busy", busy, 0);
    chk("nom_credit", dut.credit_q, 8);
    chk("nom_idx_hold", bus.blk_idx, 4);
    auto_md = 0;
    kick(12);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      n += int'(bus.bf_valid);
      step();
    end
    chk("stall_count", n, 8);
    chk("stall_ready", bus.in_ready, 0);
    pop_man = 1;
    step();
    pop_man = 0;
    chk("pop1_valid", bus.bf_valid, 1);
    chk("pop1_idx", bus.blk_idx, 8);
    step();
    chk("pop1_stall", bus.in_ready, 0);
    pop_man = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) pop_man = 0;
      #1;
      n += int'(bus.bf_valid);
      if (bus.bf_valid) chk("pop3_eof", bus.eof, bus.blk_idx == 11);
      step();
    end
    chk("pop3_count", n, 3);
    chk("drain_busy", busy, 1);
    vout_man = 1;
    for (int i = 0; i < 12; i++) step();
    vout_man = 0;
    chk("drain_done", done, 1);
    chk("drain_err", err, 0);
    pop_man = 1;
    for (int i = 0; i < 8; i++) step();
    pop_man = 0;
    chk("refill_credit", dut.credit_q, 8);
    chk("refill_err", err, 0);
    kick(2);
    chk("sim_idx0", bus.blk_idx, 0);
    step();
    vout_man = 1;
    pop_man = 1;
    #1;
    chk("sim_eof", bus.eof, 1);
    step();
    chk("sim_inflight", dut.inflight_q, 1);
    chk("sim_credit", dut.credit_q, 7);
    chk("sim_err", err, 0);
    step();
    vout_man = 0;
    pop_man = 0;
    chk("sim_done", done, 1);
    chk("sim_credit_back", dut.credit_q, 8);
    step();
    vout_man = 1;
    step();
    vout_man = 0;
    chk("spur_err", err, 3'b001);
    chk("spur_inflight", dut.inflight_q, 0);
    kick(10);
    for (int i = 0; i < 5; i++) step();
    chk("mid_idx", bus.blk_idx, 5);
    chk("mid_credit", dut.credit_q, 3);
    rstn = 0;
    step();
    rstn = 1;
    chk("mrst_ready", bus.in_ready, 0);
    chk("mrst_valid", bus.bf_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_idx", bus.blk_idx, 0);
    chk("mrst_sof_eof", {bus.sof, bus.eof}, 0);
    chk("mrst_credit", dut.credit_q, 8);
    chk("mrst_inflight", dut.inflight_q, 0);
    kick(2);
    chk("re_b0", {bus.bf_valid, bus.blk_idx, bus.sof, bus.eof}, {1'b1, 6'd0, 1'b1, 1'b0});
    step();
    chk("re_b1", {bus.bf_valid, bus.blk_idx, bus.sof, bus.eof}, {1'b1, 6'd1, 1'b0, 1'b1});
    step();
    chk("re_after", bus.bf_valid, 0);
    chk("re_credit", dut.credit_q, 6);
    vout_man = 1;
    pop_man = 1;
    step();
    step();
    vout_man = 0;
    pop_man = 0;
    chk("re_done", done, 1);
    bus.in_valid = 0;
    step();
    kick(0);
    chk("bad0_busy", busy, 0);
    chk("bad0_err", err, 3'b010);
    kick(33);
    chk("bad33_busy", busy, 0);
    chk("bad33_err", err, 3'b010);
    chk("bad33_done", done, 0);
    step();
    chk("bad_nodone", done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
